// File: rtl/loader_pkg.sv
// Shared types and constants for the serial memory loader.
// State encoding, error codes and the default frame start marker.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_SUM
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SUM     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    function automatic int byte_count(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse for an asynchronous strobe.
// Pulse appears two cycles after the edge is first sampled; no backpressure, one pulse per edge.
module strobe_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/serial_mem_loader.sv
// Parses a framed serial image (sync, addr, len, data, sum) into byte write strobes; holds busy during a frame.
// rx_ready edge to wr_en is 3 cycles; no backpressure, bytes must arrive at least 4 cycles apart.
module serial_mem_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          LEN_W     = 16,
    parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
    parameter logic [23:0] TIMEOUT   = 24'd1_000_000,
    parameter bit          CHECK_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int AB = byte_count(ADDR_W);
    localparam int LB = byte_count(LEN_W);

    logic accept;

    strobe_sync u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (rx_ready),
        .pulse_o (accept)
    );

    state_t              state_q,    state_d;
    logic [3:0]          idx_q,      idx_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [LEN_W-1:0]    len_q,      len_d;
    logic [7:0]          sum_q,      sum_d;
    logic [23:0]         tmo_q,      tmo_d;
    logic                wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic [7:0]          wr_data_q,  wr_data_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [8*AB-1:0]     addr_ext;
    logic [8*LB-1:0]     len_ext;
    logic [LEN_W-1:0]    len_new;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        len_d      = len_q;
        sum_d      = sum_q;
        tmo_d      = (state_q != ST_IDLE) ? tmo_q + 24'd1 : '0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;

        // Multi-byte fields arrive LSB first; bits beyond the field width fall away.
        addr_ext = (8*AB)'(addr_q);
        len_ext  = (8*LB)'(len_q);
        for (int i = 0; i < AB; i++) begin
            if (idx_q == 4'(i)) addr_ext[8*i +: 8] = rx_byte;
        end
        for (int i = 0; i < LB; i++) begin
            if (idx_q == 4'(i)) len_ext[8*i +: 8] = rx_byte;
        end
        len_new = LEN_W'(len_ext);

        if (accept) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d    = ST_ADDR;
                        idx_d      = '0;
                        addr_d     = '0;
                        len_d      = '0;
                        sum_d      = '0;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                    end
                end
                ST_ADDR: begin
                    sum_d  = sum_q + rx_byte;
                    addr_d = ADDR_W'(addr_ext);
                    if (idx_q == 4'(AB - 1)) begin
                        idx_d   = '0;
                        state_d = ST_LEN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                ST_LEN: begin
                    sum_d = sum_q + rx_byte;
                    len_d = len_new;
                    if (idx_q == 4'(LB - 1)) begin
                        idx_d = '0;
                        if (len_new != '0) begin
                            state_d = ST_DATA;
                        end else if (CHECK_EN) begin
                            state_d = ST_SUM;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    sum_d     = sum_q + rx_byte;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = rx_byte;
                    addr_d    = addr_q + ADDR_W'(1);
                    len_d     = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        if (CHECK_EN) begin
                            state_d = ST_SUM;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_SUM: begin
                    state_d = ST_IDLE;
                    if (rx_byte == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SUM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && TIMEOUT != '0 && tmo_q + 24'd1 == TIMEOUT) begin
            // An accept in the expiring cycle takes the branch above instead.
            state_d    = ST_IDLE;
            tmo_d      = '0;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        wr_en    = wr_en_q;
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
        done     = done_q;
        err      = err_q;
        err_code = err_code_q;
    end

endmodule

// File: tb/tb_serial_mem_loader.sv
module tb_serial_mem_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_ready = 1'b0;
    logic        busy, wr_en, done, err;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    serial_mem_loader #(
        .ADDR_W   (16),
        .LEN_W    (16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (24'd100),
        .CHECK_EN (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the list of memory writes a frame must produce, plus counters.
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_q[$];
    int          done_cnt = 0;
    logic [15:0] last_a = '0;
    logic [7:0]  last_d = '0;
    logic [7:0]  dq[$];
    logic [7:0]  s;

    always @(negedge clk) begin
        if (!reset_n) begin
            last_a = '0;
            last_d = '0;
        end else begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wr_addr, wr_data);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(w.a));
                    chk("wr_data", 32'(wr_data), 32'(w.d));
                    last_a = w.a;
                    last_d = w.d;
                end
            end else begin
                chk("hold_addr", 32'(wr_addr), 32'(last_a));
                chk("hold_data", 32'(wr_data), 32'(last_d));
            end
            if (done) done_cnt++;
        end
    end

    // Raise rx_ready just after an edge; lat = edges after raising at which wr_en was first seen.
    task automatic send_byte(input logic [7:0] b, output int lat);
        lat = 0;
        @(posedge clk); #1;
        rx_byte  = b;
        rx_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 4) rx_ready = 1'b0;
            if (wr_en && lat == 0) lat = k;
        end
    endtask

    task automatic send_frame(input logic [15:0] base, input bit corrupt, output logic [7:0] sum_out);
        logic [7:0]  fr[$];
        logic [7:0]  sm;
        logic [15:0] len;
        int          d0;
        int          lat;
        len = 16'(dq.size());
        fr = '{8'hA5, base[7:0], base[15:8], len[7:0], len[15:8]};
        foreach (dq[i]) fr.push_back(dq[i]);
        sm = 8'h00;
        for (int i = 1; i < fr.size(); i++) sm = sm + fr[i];
        fr.push_back(corrupt ? sm + 8'd1 : sm);
        foreach (dq[i]) exp_q.push_back('{a: base + 16'(i), d: dq[i]});
        d0 = done_cnt;
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], lat);
            if (i >= 5 && i < fr.size() - 1) chk("wr_latency", 32'(lat - 1), 32'd3);
            if (i == 0) chk("err_cleared_on_sync", 32'(err), 32'd0);
            if (i < fr.size() - 1) chk("busy_mid_frame", 32'(busy), 32'd1);
        end
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("done_count", 32'(done_cnt - d0), corrupt ? 32'd0 : 32'd1);
        chk("err", 32'(err), corrupt ? 32'd1 : 32'd0);
        chk("err_code", 32'(err_code), corrupt ? 32'd1 : 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        sum_out = sm;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
    endtask

    initial begin
        int lat;
        int d0;
        int drop;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: nominal frame at 0x4000
        dq = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h4000, 1'b0, s);
        chk("model_sum_frame1", 32'(s), 32'h0000_00A9);

        // 2: same frame, bad trailer (0xAA)
        dq = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h4000, 1'b1, s);
        chk("model_sum_frame2", 32'(s), 32'h0000_00A9);

        // 3: address wrap, SYNC value inside data
        dq = '{8'hA5, 8'h5A, 8'h01};
        send_frame(16'hFFFE, 1'b0, s);
        chk("model_sum_frame3", 32'(s), 32'h0000_0000);

        // 4: zero length
        dq.delete();
        send_frame(16'h4000, 1'b0, s);
        chk("model_sum_frame4", 32'(s), 32'h0000_0040);

        // 5: timeout after partial header, then a fresh frame clears err
        d0 = done_cnt;
        send_byte(8'hA5, lat);
        chk("to_busy_after_sync", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rx_byte  = 8'h00;
        rx_ready = 1'b1;
        drop = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k == 4) rx_ready = 1'b0;
            if (!busy) begin
                drop = k;
                break;
            end
        end
        chk("timeout_busy_drop_edge", 32'(drop), 32'd104);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_err_code", 32'(err_code), 32'd2);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        repeat (5) @(posedge clk);
        dq = '{8'h77};
        send_frame(16'h0010, 1'b0, s);
        chk("model_sum_frame5", 32'(s), 32'h0000_0088);

        // 6: reset in the middle of DATA, garbage in IDLE, then a fresh frame
        send_byte(8'hA5, lat);
        send_byte(8'h00, lat);
        send_byte(8'h50, lat);
        send_byte(8'h05, lat);
        send_byte(8'h00, lat);
        exp_q.push_back('{a: 16'h5000, d: 8'h01});
        send_byte(8'h01, lat);
        exp_q.push_back('{a: 16'h5001, d: 8'h02});
        send_byte(8'h02, lat);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        chk("pre_reset_writes", 32'(exp_q.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        send_byte(8'h03, lat);
        send_byte(8'h00, lat);
        send_byte(8'hFF, lat);
        chk("idle_garbage_busy", 32'(busy), 32'd0);
        chk("idle_garbage_err", 32'(err), 32'd0);
        dq = '{8'hC3, 8'h3C};
        send_frame(16'h6000, 1'b0, s);
        chk("model_sum_frame6", 32'(s), 32'h0000_0061);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
